// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the 16-bit core.
// Handles stalls, branch/jump redirects, slow instruction memory and HLT.
module if_id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_addr,
    input  logic        jump,
    input  logic [15:0] jump_addr,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_ready,
    output logic [15:0] instr,
    output logic [15:0] pc_plus1,
    output logic        valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HALT
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pending;
    logic        drop;

    logic        redirect;
    logic [15:0] target;
    logic [15:0] pc_inc;
    logic        is_hlt;

    // Branch has priority over jump when both redirect in the same cycle.
    assign redirect  = branch_taken | jump;
    assign target    = branch_taken ? branch_addr : jump_addr;
    assign pc_inc    = pc + 16'd1;
    assign is_hlt    = (imem_data[15:12] == 4'hF);
    assign imem_addr = pc;
    assign imem_rd   = (state != HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= 16'h0000;
            pending  <= 16'h0000;
            drop     <= 1'b0;
            instr    <= 16'h0000;
            pc_plus1 <= 16'h0000;
            valid    <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc    <= target;
                        instr <= 16'h0000;
                        valid <= 1'b0;
                    end else if (!stall) begin
                        if (imem_ready) begin
                            instr    <= imem_data;
                            pc_plus1 <= pc_inc;
                            valid    <= 1'b1;
                            if (is_hlt) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end else begin
                                pc <= pc_inc;
                            end
                        end else begin
                            state <= WAIT;
                            instr <= 16'h0000;
                            valid <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    // The outstanding read must complete at the old address before
                    // the PC may move, so redirects are parked until data returns.
                    if (imem_ready && (drop || redirect)) begin
                        pc    <= redirect ? target : pending;
                        drop  <= 1'b0;
                        state <= FETCH;
                        instr <= 16'h0000;
                        valid <= 1'b0;
                    end else if (redirect) begin
                        pending <= target;
                        drop    <= 1'b1;
                    end else if (imem_ready && !stall) begin
                        instr    <= imem_data;
                        pc_plus1 <= pc_inc;
                        valid    <= 1'b1;
                        if (is_hlt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc    <= pc_inc;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    if (redirect) begin
                        pc     <= target;
                        halted <= 1'b0;
                        state  <= FETCH;
                        instr  <= 16'h0000;
                        valid  <= 1'b0;
                    end else if (!stall) begin
                        instr <= 16'h0000;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: instructions consumed by decode are checked
// against a scoreboard queue; control outputs are checked at fixed points.
module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_addr;
    logic        jump;
    logic [15:0] jump_addr;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_ready;
    logic [15:0] instr;
    logic [15:0] pc_plus1;
    logic        valid;
    logic        halted;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus1;
    } sb_entry_t;

    sb_entry_t   exp_q[$];
    logic [15:0] mem[256];
    int          n_checks = 0;
    int          n_errors = 0;

    if_id_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .imem_data    (imem_data),
        .imem_ready   (imem_ready),
        .instr        (instr),
        .pc_plus1     (pc_plus1),
        .valid        (valid),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive the inputs for the next rising edge, then settle just after it.
    task automatic applyStimulus(input logic st, input logic bt, input logic [15:0] ba,
                                 input logic jp, input logic [15:0] ja, input logic rdy);
        stall        = st;
        branch_taken = bt;
        branch_addr  = ba;
        jump         = jp;
        jump_addr    = ja;
        imem_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpect(input logic [15:0] i, input logic [15:0] p);
        exp_q.push_back('{instr: i, pc_plus1: p});
    endtask

    // Decode consumes IF/ID whenever it is valid and not stalling.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid && !stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL sb_unexpected: got instr %h pc_plus1 %h, expected nothing",
                             instr, pc_plus1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_instr", instr, e.instr);
                    checkOutput("sb_pc_plus1", pc_plus1, e.pc_plus1);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h0571;
        mem[1] = 16'h2145;
        mem[2] = 16'h1234;
        mem[5] = 16'hF000;

        rst_n = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_addr = 16'h0;
        jump = 1'b0; jump_addr = 16'h0; imem_ready = 1'b1;
        #2;
        checkOutput("rst_instr", instr, 16'h0000);
        checkOutput("rst_valid", {15'd0, valid}, 16'd0);
        checkOutput("rst_halted", {15'd0, halted}, 16'd0);
        checkOutput("rst_addr", imem_addr, 16'h0000);
        checkOutput("rst_rd", {15'd0, imem_rd}, 16'd1);

        @(posedge clk); #1;
        rst_n = 1'b1;
        pushExpect(16'h0571, 16'h0001);
        pushExpect(16'h2145, 16'h0002);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);
        checkOutput("fetch_addr", imem_addr, 16'h0002);

        // Stall two cycles with 0x2145 in IF/ID.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 0, 16'h0, 0, 16'h0, 1);
            checkOutput("stall_instr", instr, 16'h2145);
            checkOutput("stall_pc_plus1", pc_plus1, 16'h0002);
            checkOutput("stall_addr", imem_addr, 16'h0002);
        end
        pushExpect(16'h1234, 16'h0003);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);

        // Simultaneous branch and jump: branch wins.
        applyStimulus(0, 1, 16'h0040, 1, 16'h0080, 1);
        checkOutput("redir_addr", imem_addr, 16'h0040);
        checkOutput("redir_valid", {15'd0, valid}, 16'd0);
        checkOutput("redir_instr", instr, 16'h0000);
        pushExpect(16'h1040, 16'h0041);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);

        // Memory not ready for 3 cycles, jump to 0x0010 during the second.
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0);
        checkOutput("wait1_addr", imem_addr, 16'h0041);
        checkOutput("wait1_valid", {15'd0, valid}, 16'd0);
        applyStimulus(0, 0, 16'h0, 1, 16'h0010, 0);
        checkOutput("wait2_addr", imem_addr, 16'h0041);
        checkOutput("wait2_valid", {15'd0, valid}, 16'd0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0);
        checkOutput("wait3_addr", imem_addr, 16'h0041);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);
        checkOutput("drop_addr", imem_addr, 16'h0010);
        checkOutput("drop_valid", {15'd0, valid}, 16'd0);
        pushExpect(16'h1010, 16'h0011);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);

        // Jump to the HLT word at 0x0005.
        applyStimulus(0, 0, 16'h0, 1, 16'h0005, 1);
        checkOutput("jmp_addr", imem_addr, 16'h0005);
        pushExpect(16'hF000, 16'h0006);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);
        checkOutput("hlt_halted", {15'd0, halted}, 16'd1);
        checkOutput("hlt_rd", {15'd0, imem_rd}, 16'd0);
        checkOutput("hlt_addr", imem_addr, 16'h0005);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);
        checkOutput("hlt_bubble", {15'd0, valid}, 16'd0);
        checkOutput("hlt_hold_addr", imem_addr, 16'h0005);
        applyStimulus(0, 1, 16'h0020, 0, 16'h0, 1);
        checkOutput("unhalt_halted", {15'd0, halted}, 16'd0);
        checkOutput("unhalt_rd", {15'd0, imem_rd}, 16'd1);
        checkOutput("unhalt_addr", imem_addr, 16'h0020);
        pushExpect(16'h1020, 16'h0021);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);

        // Reset asserted in the middle of a WAIT.
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0);
        checkOutput("prerst_addr", imem_addr, 16'h0021);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_addr", imem_addr, 16'h0000);
        checkOutput("midrst_instr", instr, 16'h0000);
        checkOutput("midrst_pc_plus1", pc_plus1, 16'h0000);
        checkOutput("midrst_valid", {15'd0, valid}, 16'd0);
        checkOutput("midrst_halted", {15'd0, halted}, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pushExpect(16'h0571, 16'h0001);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);
        checkOutput("restart_addr", imem_addr, 16'h0001);

        @(negedge clk); #1;
        stall = 1'b1;
        @(posedge clk); #1;
        checkOutput("sb_drain", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
